// File: rtl/fifo_cdc.sv
// fifo_cdc: streaming byte FIFO between the receive MAC and the parser.
// Single clock, auto-draining: each accepted word appears exactly once on
// rdDataOut, in order, qualified by a one-cycle rdDataValidOut strobe.
//
// Output handshake: valid-only. rdDataOut carries a new word on every cycle
// where rdDataValidOut is high. There is no ready input, so the consumer
// must take the word on that cycle. rdDataOut holds its last value otherwise.
//
// XPERIMENTAL_LOW_LAT_CDC picks how far the read side lags the write
// pointer. 1 means the read side uses the registered wrPtr directly. 0 means
// the read side sees wrPtr through two extra register stages. That adds two
// cycles of latency and keeps the pointer path ready for a future split
// into two clock domains.
//
// DEPTH must be a power of two and at least 4. The pointers carry one extra
// wrap bit, which lets full and empty be told apart without a counter.
module fifo_cdc #(
    parameter int DATA_WIDTH              = 8,
    parameter int DEPTH                   = 16,
    parameter bit XPERIMENTAL_LOW_LAT_CDC = 1'b0
) (
    input  logic                  clkIn,
    input  logic                  rstNIn,
    input  logic                  wrEnIn,
    input  logic [DATA_WIDTH-1:0] wrDataIn,
    output logic [DATA_WIDTH-1:0] rdDataOut,
    output logic                  rdDataValidOut,
    output logic                  fullOut,
    output logic                  overflowOut
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    // Reset release synchronizer. Writes are accepted once the release has
    // travelled through both flops, which happens on the 3rd edge after
    // rstNIn rises.
    logic [1:0]            rstSync;
    logic                  writeReady;

    // Binary pointers with one wrap bit above the address bits.
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W-1:0]      wrPtrD1;
    logic [PTR_W-1:0]      wrPtrD2;
    logic [PTR_W-1:0]      visWrPtr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  isEmpty;
    logic                  doWrite;
    logic                  doRead;

    assign writeReady = rstSync[1];

    // The read side compares against the delayed pointer in conservative
    // mode. This is why a word written on edge N is never read on edge N.
    assign visWrPtr = XPERIMENTAL_LOW_LAT_CDC ? wrPtr : wrPtrD2;

    // Full uses the real pointers on both sides. The visible pointer only
    // lags behind, so occupancy is never underestimated.
    assign fullOut = (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]) &&
                     (wrPtr[ADDR_W] != rdPtr[ADDR_W]);

    assign isEmpty = (rdPtr == visWrPtr);
    assign doWrite = wrEnIn && writeReady && !fullOut;
    assign doRead  = !isEmpty;

    // Shift ones into the synchronizer after the reset is released.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            rstSync <= 2'b00;
        end else begin
            rstSync <= {rstSync[0], 1'b1};
        end
    end

    // Advance the write pointer on every accepted write.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            wrPtr <= '0;
        end else if (doWrite) begin
            wrPtr <= wrPtr + PTR_W'(1);
        end
    end

    // Storage array. It is not reset, because the pointers alone decide
    // which entries are live.
    always_ff @(posedge clkIn) begin
        if (doWrite) begin
            mem[wrPtr[ADDR_W-1:0]] <= wrDataIn;
        end
    end

    // Two-stage delay of the write pointer toward the read side.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            wrPtrD1 <= '0;
            wrPtrD2 <= '0;
        end else begin
            wrPtrD1 <= wrPtr;
            wrPtrD2 <= wrPtrD1;
        end
    end

    // Auto-drain: present one word per cycle while the read side sees data.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            rdPtr          <= '0;
            rdDataOut      <= '0;
            rdDataValidOut <= 1'b0;
        end else if (doRead) begin
            rdPtr          <= rdPtr + PTR_W'(1);
            rdDataOut      <= mem[rdPtr[ADDR_W-1:0]];
            rdDataValidOut <= 1'b1;
        end else begin
            rdDataValidOut <= 1'b0;
        end
    end

    // Sticky overflow flag. Writes ignored during reset release do not
    // count as overflow attempts.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            overflowOut <= 1'b0;
        end else if (wrEnIn && writeReady && fullOut) begin
            overflowOut <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_cdc.sv
// Bench for fifo_cdc. Three instances share one stimulus stream:
//   u0: DEPTH 16, low-latency pointer path
//   u1: DEPTH 16, conservative pointer path
//   u2: DEPTH 4,  conservative pointer path
// Each instance has its own reference model. The model holds a queue of
// accepted words, each tagged with the edge on which it becomes readable.
module tb_fifo_cdc;

    localparam int NINST = 3;

    logic       clkIn;
    logic       rstNIn;
    logic       wrEnIn;
    logic [7:0] wrDataIn;

    logic [7:0] rdData  [NINST];
    logic       rdValid [NINST];
    logic       full    [NINST];
    logic       ovf     [NINST];

    int testCount = 0;
    int failCount = 0;

    // Reference parameters per instance.
    int latency [NINST] = '{1, 3, 3};
    int depth   [NINST] = '{16, 16, 4};

    // Reference model state.
    logic [7:0] expQ     [NINST][$];
    int         dueQ     [NINST][$];
    logic [7:0] holdData [NINST];
    logic       expOvf   [NINST];
    int         edgeNum;
    int         sinceRel;

    fifo_cdc #(.DATA_WIDTH(8), .DEPTH(16), .XPERIMENTAL_LOW_LAT_CDC(1'b1)) u0 (
        .clkIn(clkIn), .rstNIn(rstNIn), .wrEnIn(wrEnIn), .wrDataIn(wrDataIn),
        .rdDataOut(rdData[0]), .rdDataValidOut(rdValid[0]),
        .fullOut(full[0]), .overflowOut(ovf[0])
    );

    fifo_cdc #(.DATA_WIDTH(8), .DEPTH(16), .XPERIMENTAL_LOW_LAT_CDC(1'b0)) u1 (
        .clkIn(clkIn), .rstNIn(rstNIn), .wrEnIn(wrEnIn), .wrDataIn(wrDataIn),
        .rdDataOut(rdData[1]), .rdDataValidOut(rdValid[1]),
        .fullOut(full[1]), .overflowOut(ovf[1])
    );

    fifo_cdc #(.DATA_WIDTH(8), .DEPTH(4), .XPERIMENTAL_LOW_LAT_CDC(1'b0)) u2 (
        .clkIn(clkIn), .rstNIn(rstNIn), .wrEnIn(wrEnIn), .wrDataIn(wrDataIn),
        .rdDataOut(rdData[2]), .rdDataValidOut(rdValid[2]),
        .fullOut(full[2]), .overflowOut(ovf[2])
    );

    // Clock and reset: 10 ns clock. Reset is driven from the stimulus block.
    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    task automatic check(input string tag, input int k,
                         input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s[u%0d] observed=0x%0h expected=0x%0h at %0t",
                   tag, k, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < NINST; k++) begin
            expQ[k].delete();
            dueQ[k].delete();
            holdData[k] = 8'h00;
            expOvf[k]   = 1'b0;
        end
        sinceRel = 0;
    endtask

    // Every output must be at its cleared value.
    task automatic checkCleared(input string tag);
        for (int k = 0; k < NINST; k++) begin
            check({tag, "_valid"}, k, 32'(rdValid[k]), 32'd0);
            check({tag, "_data"},  k, 32'(rdData[k]),  32'd0);
            check({tag, "_full"},  k, 32'(full[k]),    32'd0);
            check({tag, "_ovf"},   k, 32'(ovf[k]),     32'd0);
        end
    endtask

    // Driver plus scoreboard. The task drives one cycle of input, advances
    // the model by one edge, then checks all instances 1 ns after the edge.
    task automatic step(input logic we, input logic [7:0] d);
        wrEnIn   = we;
        wrDataIn = d;
        @(posedge clkIn);
        #1;
        edgeNum++;
        if (sinceRel < 1000) sinceRel++;
        for (int k = 0; k < NINST; k++) begin
            logic fullPre;
            logic expValid;
            fullPre  = (expQ[k].size() == depth[k]);
            expValid = 1'b0;
            if (expQ[k].size() > 0 && dueQ[k][0] <= edgeNum) begin
                expValid    = 1'b1;
                holdData[k] = expQ[k].pop_front();
                void'(dueQ[k].pop_front());
            end
            if (we && sinceRel >= 3) begin
                if (fullPre) begin
                    expOvf[k] = 1'b1;
                end else begin
                    expQ[k].push_back(d);
                    dueQ[k].push_back(edgeNum + latency[k]);
                end
            end
            check("valid", k, 32'(rdValid[k]), 32'(expValid));
            check("data",  k, 32'(rdData[k]),  32'(holdData[k]));
            check("full",  k, 32'(full[k]),    32'(expQ[k].size() == depth[k]));
            check("ovf",   k, 32'(ovf[k]),     32'(expOvf[k]));
        end
    endtask

    initial begin
        rstNIn   = 1'b1;
        wrEnIn   = 1'b0;
        wrDataIn = 8'h00;
        edgeNum  = 0;
        modelReset();

        // Power-on reset clears everything without a clock edge.
        #1 rstNIn = 1'b0;
        #1 checkCleared("por");
        @(posedge clkIn);
        @(posedge clkIn);
        #1 rstNIn = 1'b1;
        modelReset();

        // The first two edges after release ignore writes. The third is stored.
        step(1'b1, 8'h11);
        step(1'b1, 8'h22);
        step(1'b1, 8'h33);
        repeat (6) step(1'b0, 8'h00);

        // Continuous stream 0..499, which crosses the pointer wrap many times.
        for (int i = 0; i < 500; i++) step(1'b1, 8'(i));
        repeat (6) step(1'b0, 8'h00);

        // Sparse writes: isolated pulses, then rdDataOut holds the last word.
        step(1'b1, 8'hA5);
        repeat (5) step(1'b0, 8'h00);
        step(1'b1, 8'h5A);
        repeat (8) step(1'b0, 8'h00);

        // Six back-to-back writes. The DEPTH 4 instance keeps pace.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i));
        repeat (6) step(1'b0, 8'h00);

        // Random write pattern and data.
        repeat (400) step(1'($urandom_range(0, 1)), 8'($urandom));
        repeat (6) step(1'b0, 8'h00);

        // Reset pulse of 1 ns while words are still in flight.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i));
        #2 rstNIn = 1'b0;
        #1 checkCleared("midrst");
        modelReset();
        rstNIn = 1'b1;

        // The first two writes after release are ignored. Output resumes
        // with 0xE3 only.
        step(1'b1, 8'hE1);
        step(1'b1, 8'hE2);
        step(1'b1, 8'hE3);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i));
        repeat (8) step(1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
